// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      HOLD = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched instruction while the output slot is busy.
module fetch_skid_buf
   import fetch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            drain,
   input  logic            flush,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

   // NOTE: payload registers carry no reset; valid alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (load && !flush) begin
         pc    <= in_pc;
         instr <= in_instr;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one read in flight, feeds the IF/ID register.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redirect_tgt;
   logic            slot_free;
   logic            skid_load;
   logic            skid_drain;
   logic            skid_valid;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_instr;

   assign imem_req     = !rst && (state != HOLD);
   assign slot_free    = !if_valid || !stall;
   assign pc_plus4     = pc + XLEN'(4);
   assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
   assign skid_load    = (state == REQ) && imem_ack && !redirect && !slot_free;
   assign skid_drain   = (state == HOLD) && slot_free && !redirect;

   fetch_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_load),
      .drain    (skid_drain),
      .flush    (redirect),
      .in_pc    (pc),
      .in_instr (imem_rdata),
      .valid    (skid_valid),
      .pc       (skid_pc),
      .instr    (skid_instr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
         if_valid  <= 1'b0;
         if_pc     <= '0;
         if_instr  <= NOP_INSTR;
      end else if (redirect) begin
         if_valid <= 1'b0;
         pc       <= redirect_tgt;
         // An unanswered request must still be drained at its old address.
         if (state != HOLD && !imem_ack) begin
            state <= DROP;
         end else begin
            state     <= REQ;
            imem_addr <= redirect_tgt;
         end
      end else begin
         // NOTE: a consumed slot defaults to empty; a later non-blocking write in this block refills it.
         if (if_valid && !stall) if_valid <= 1'b0;
         case (state)
            REQ: begin
               if (imem_ack) begin
                  pc        <= pc_plus4;
                  imem_addr <= pc_plus4;
                  if (slot_free) begin
                     if_valid <= 1'b1;
                     if_pc    <= pc;
                     if_instr <= imem_rdata;
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (slot_free) begin
                  if_valid <= skid_valid;
                  if_pc    <= skid_pc;
                  if_instr <= skid_instr;
                  state    <= REQ;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state     <= REQ;
                  imem_addr <= pc;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V core. Owns the program counter, issues one-outstanding-request reads to instruction memory, and presents fetched instructions with their PC to the IF/ID pipeline register. Downstream it is throttled by `stall` from the hazard unit. Upstream it is redirected by `redirect` from branch/jump resolution.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `imem_req`  out  1: read request, level; held until `imem_ack`.
- `imem_addr`  out  XLEN: address of outstanding request; stable while `imem_req`=1.
- `imem_ack`  in  1: read data valid this cycle; legal only while `imem_req`=1, may assert in the first request cycle.
- `imem_rdata`  in  32: instruction word, sampled when `imem_ack`=1.
- `stall`  in  1: downstream not accepting; `if_*` must hold.
- `redirect`  in  1: flush and restart fetch at `redirect_pc`; overrides `stall`.
- `redirect_pc`  in  XLEN: target; bits [1:0] forced to 0.
- `if_valid`  out  1: `if_instr`/`if_pc` hold a live instruction.
- `if_pc`  out  XLEN: PC of `if_instr`.
- `if_instr`  out  32: instruction word.

## Operation
- Reset values:
  - `pc`=RESET_PC, `imem_addr`=RESET_PC, state=REQ.
  - `imem_req`=0 during reset, 1 from the first cycle after release.
  - `if_valid`=0, `if_pc`=0, `if_instr`=32'h0000_0013 (NOP).
  - Skid buffer empty.
- Transfer to the consumer: occurs on an edge where `if_valid`=1 and `stall`=0. The output slot is free if `if_valid`=0 or a transfer occurs this edge.
- States:
  - **REQ**: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ack` with no `redirect` and the slot free: load `if_instr`/`if_pc`, set `if_valid`=1, `pc`←`pc`+4, stay in REQ with the new address.
    - On `imem_ack` with no `redirect` and the slot not free: capture into the skid buffer, `pc`←`pc`+4, go to HOLD.
    - No `imem_ack`: stay in REQ.
  - **HOLD**: `imem_req`=0. When the slot frees, the skid buffer moves to the output (`if_valid`=1) and the state returns to REQ.
  - **DROP**: `imem_req`=1 with the old `imem_addr`. Data returned by `imem_ack` is discarded, then the state goes to REQ at `pc`.
- `redirect`, in any state:
  - `if_valid`←0 and the skid buffer is emptied.
  - `pc`←`redirect_pc`&~3.
  - If a request is outstanding without `imem_ack` this cycle: go to DROP.
  - Otherwise: go to REQ with the new address. An `imem_ack` in the same cycle is discarded.
- `redirect` during DROP: updates `pc` only and stays in DROP.
- Arithmetic: `pc`+4 wraps modulo 2^XLEN; no trap is generated.
- Reset mid-operation: any outstanding request is abandoned, and the memory model is reset with the core.

## Timing
- Zero-wait memory (ack in the first request cycle): first `if_valid` one cycle after reset release, then 1 instruction/cycle while `stall`=0.
- Memory latency of N wait cycles: throughput of 1 instruction per N+1 cycles.
- `stall`: held for K cycles freezes all `if_*` outputs for exactly K cycles. At most one further instruction is fetched into the skid buffer; no request is issued while HOLD persists.
- `redirect`: the first target instruction appears at `if_valid` no earlier than 1 cycle after the redirect edge (zero-wait, no outstanding request). With a request in flight, it is delayed by the remaining latency of that request plus 1.
- All outputs are registered except `imem_req`, which is decoded from the state.

## Structure
- Package `fetch_pkg`:
  - State enum {REQ, HOLD, DROP}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `RESET_PC` default.
- Sub-module `fetch_skid_buf`: one-entry buffer (pc+instr+valid) with load/drain/flush controls.

## Test plan
- Reset release, zero-wait memory returning `rdata`=addr: `imem_addr` 0,4,8,…; `if_pc` 0,4,8 on consecutive cycles with `if_valid`=1.
- Memory with 2 wait states: one instruction every 3 cycles. `imem_addr` stays stable while `imem_req`=1.
- `stall`=1 for 4 cycles at `if_pc`=8: outputs frozen at 8. Skid buffer holds 12 with no request during HOLD. After release, 12 is presented next cycle, then 16 follows.
- `redirect` to 0x103 while a 3-wait-state request to 0x20 is outstanding: stale data is dropped and `if_valid`=0 during DROP. The next request goes to 0x100, and `if_pc`=0x100 appears.
- `redirect` during HOLD with `stall`=1: `if_valid` goes to 0 next cycle, the skid buffer is cleared, and fetch restarts at the target.
- `rst` asserted mid-request, and wrap with `RESET_PC`=32'hFFFF_FFFC:
  - Reset mid-request: all reset values appear immediately.
  - Wrap case: the fetch after 0xFFFF_FFFC is 0x0000_0000.
